// File: rtl/lit_table_streamer_pkg.sv
// Shared types and the default constant table for lit_table_streamer.
package lit_stream_pkg;

    typedef logic [7:0] lit_word_t;

    typedef enum logic {
        IDLE,
        STREAM
    } lit_state_e;

    localparam lit_word_t DEFAULT_TABLE [4] = '{8'd10, 8'd20, 8'd30, 8'd40};

endpackage

// File: rtl/lit_table_streamer.sv
// lit_table_streamer: streams a constant, literal-initialised table out over
// a valid/ready interface, one burst per accepted start.
// Optional build macro: LIT_STREAM_CHECKSUM_EN adds a running XOR checksum
// of every accepted beat on the checksum output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs other than data/idx are quiet
// STREAM | presenting beats; out_valid held until each handshake
module lit_table_streamer
    import lit_stream_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,   // at least 2, so the index is never zero bits wide
    parameter logic [DW-1:0] TABLE [DEPTH] = DEFAULT_TABLE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     burst_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(DEPTH)-1:0]   out_idx,
    output logic                       out_last,
    output logic                       busy,
`ifdef LIT_STREAM_CHECKSUM_EN
    output logic [DW-1:0]              checksum,
`endif
    output logic                       done
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    lit_state_e    state;
    logic [LW-1:0] len;
    logic [LW-1:0] eff_len;
    logic [IW-1:0] nxt_idx;
    logic          nxt_last;

    // Effective burst length: 0 and anything past the table size mean the whole table.
    always_comb begin
        eff_len = DEPTH_L;
        if (burst_len != '0 && burst_len <= DEPTH_L) begin
            eff_len = burst_len;
        end
    end

    assign nxt_idx  = out_idx + IW'(1);
    assign nxt_last = ({1'b0, nxt_idx} == (len - LW'(1)));

    // Burst sequencer; out_valid is 1 throughout STREAM, so out_ready alone marks a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LIT_STREAM_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        len       <= eff_len;
                        out_idx   <= '0;
                        out_data  <= TABLE[0];
                        out_valid <= 1'b1;
                        out_last  <= (eff_len == LW'(1));
                        busy      <= 1'b1;
`ifdef LIT_STREAM_CHECKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (out_ready) begin
`ifdef LIT_STREAM_CHECKSUM_EN
                        checksum <= checksum ^ out_data;
`endif
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_data <= TABLE[nxt_idx];
                            out_last <= nxt_last;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/lit_table_streamer.md
Name: lit_table_streamer

Overview:
Reader/transmitter side of the literal-initialised storage pattern. It holds a constant unpacked table built from an array-literal parameter. On request, it streams the table entries out over a valid/ready interface. It sits between configuration/constant storage and any downstream consumer that needs the constants one word at a time, such as coefficient or pattern loaders.

Parameters:
DW, 8, width of each table word.
DEPTH, 4, number of table entries; must be >= 2.
TABLE, lit_stream_pkg::DEFAULT_TABLE ('{8'd10, 8'd20, 8'd30, 8'd40}), unpacked constant array, logic [DW-1:0] [DEPTH]; entry 0 is sent first.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request one burst; sampled only in IDLE.
burst_len  input  $clog2(DEPTH)+1  beats to send; 0 means DEPTH; values > DEPTH clamp to DEPTH.
out_valid  output  1  out_data/out_idx/out_last hold a valid beat.
out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
out_data  output  DW  TABLE[out_idx].
out_idx  output  $clog2(DEPTH)  index of the current beat.
out_last  output  1  current beat is the final beat of the burst.
busy  output  1  high in STREAM.
done  output  1  single-cycle pulse after the final handshake.

Behaviour:
- Reset (async, active-high): state IDLE; out_valid, out_data, out_idx, out_last, busy and done are all 0; the latched length is 0.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is produced. After release, the block waits in IDLE.
- FSM states are IDLE and STREAM.
- IDLE -> STREAM on clock edge with start=1:
  - latch the effective length L (burst_len rule above);
  - set out_idx=0, out_data=TABLE[0], out_valid=1, out_last=(L==1), busy=1.
- Latency: the first beat is valid in the cycle after start is sampled.
- STREAM, beat accepted and not last:
  - out_idx increments; out_data=TABLE[out_idx+1];
  - out_last asserts when the new index == L-1.
  - With out_ready held high, the block sends one beat per cycle with no bubbles.
- STREAM, no handshake (out_valid && !out_ready): out_data, out_idx and out_last hold stable; out_valid stays 1. out_valid never drops before a handshake.
- STREAM, last beat accepted: go to IDLE; out_valid=0, out_last=0, busy=0, done=1 for exactly one cycle. out_data and out_idx hold their last values.
- start while in STREAM, or in the same cycle as the last handshake, is ignored and is not queued.
- start in the cycle done is high (state IDLE) is accepted normally, so back-to-back bursts have one idle cycle between them.
- All outputs are registered; there is no combinational path from out_ready to out_valid.
- Index arithmetic is unsigned, width $clog2(DEPTH). The index never wraps within a burst because L <= DEPTH.

Optional Feature:
Macro LIT_STREAM_CHECKSUM_EN.
- Defined:
  - adds output port checksum [DW-1:0];
  - cleared to 0 on reset and when start is accepted;
  - XORs in out_data on every handshake;
  - holds its value after done until the next accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package lit_stream_pkg holds:
  - typedef lit_word_t (logic [7:0]);
  - typedef enum logic {IDLE, STREAM} lit_state_e;
  - localparam lit_word_t DEFAULT_TABLE [4] = '{10, 20, 30, 40}.
- No sub-module: the FSM, index counter and output registers fit one module (~150 lines).

Test Plan:
1. Full burst with no backpressure: reset, out_ready=1, start=1, burst_len=0 for one cycle.
   - Expect out_data 10, 20, 30, 40 on the next 4 cycles, with out_idx 0..3 and out_last only on 40.
   - Expect done one cycle after the 40 handshake; busy high for exactly 4 cycles.
2. Backpressure: burst_len=4; out_ready low for 3 cycles while out_data=20.
   - Expect 20/idx1 stable and out_valid held through those cycles; sequence resumes 30, 40 with no beat lost or duplicated.
3. Short and clamped lengths:
   - burst_len=2 -> beats 10, 20, out_last on 20, done.
   - burst_len=7 (with DEPTH=4 and a 3-bit port) -> clamped to 4 beats.
4. Start collisions:
   - start pulsed during STREAM and on the last-beat cycle -> ignored; exactly one burst occurs.
   - start in the done cycle -> new burst, first beat 10 on the next cycle.
5. Reset mid-burst: assert reset during beat idx=2.
   - Expect all outputs 0 immediately, no done pulse, state IDLE.
   - A subsequent start restarts at 10.
6. LIT_STREAM_CHECKSUM_EN defined, full burst -> checksum = 0x28 (10^20^30^40) at done, held until the next start, then cleared to 0.
